// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared coin codes, selection error codes and controller states
package vend_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_C1   = 2'b01;
  localparam logic [1:0] COIN_C2   = 2'b10;
  localparam logic [1:0] COIN_C3   = 2'b11;

  localparam logic [1:0] SEL_OK        = 2'b00;
  localparam logic [1:0] SEL_NO_CREDIT = 2'b01;
  localparam logic [1:0] SEL_SOLD_OUT  = 2'b10;
  localparam logic [1:0] SEL_BUSY      = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    PAYOUT = 1'b1
  } state_t;

endpackage

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - combinational greedy picker: largest coin not exceeding the remainder
module change_dispenser
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 8,
  parameter int COIN1    = 5,
  parameter int COIN2    = 10,
  parameter int COIN3    = 25
) (
  input  logic [CREDIT_W-1:0] remain_i,
  output logic [1:0]          coin_o,
  output logic [CREDIT_W-1:0] value_o
);

  localparam logic [CREDIT_W-1:0] V1 = CREDIT_W'(COIN1);
  localparam logic [CREDIT_W-1:0] V2 = CREDIT_W'(COIN2);
  localparam logic [CREDIT_W-1:0] V3 = CREDIT_W'(COIN3);

  // Each candidate only wins if it fits and beats the best so far, so coin ordering is free.
  always_comb begin
    coin_o  = COIN_NONE;
    value_o = '0;
    if (remain_i >= V1 && V1 > value_o) begin
      coin_o  = COIN_C1;
      value_o = V1;
    end
    if (remain_i >= V2 && V2 > value_o) begin
      coin_o  = COIN_C2;
      value_o = V2;
    end
    if (remain_i >= V3 && V3 > value_o) begin
      coin_o  = COIN_C3;
      value_o = V3;
    end
  end

endmodule

// File: rtl/vend_ctrl_param.sv
// rtl/vend_ctrl_param.sv - multi-item vending controller with saturating credit,
// per-item stock and one-coin-per-cycle change payout
module vend_ctrl_param
  import vend_pkg::*;
#(
  parameter int NUM_ITEMS  = 4,
  parameter int ID_W       = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1,
  parameter int CREDIT_W   = 8,
  parameter int STOCK_W    = 4,
  parameter int COIN1      = 5,
  parameter int COIN2      = 10,
  parameter int COIN3      = 25,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {8'd50, 8'd35, 8'd25, 8'd15},
  parameter int INIT_STOCK = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          coin,
  input  logic                select_valid,
  input  logic [ID_W-1:0]     select_id,
  input  logic                cancel,
  input  logic                refill_valid,
  input  logic [ID_W-1:0]     refill_id,
  input  logic [STOCK_W-1:0]  refill_cnt,
  output logic                item_valid,
  output logic [ID_W-1:0]     item_id,
  output logic [1:0]          change_coin,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic [1:0]          sel_err
);

  state_t                state_q, state_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic [STOCK_W-1:0]    stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0]    stock_d [NUM_ITEMS];
  logic                  item_valid_q, item_valid_d;
  logic [ID_W-1:0]       item_id_q, item_id_d;
  logic [1:0]            change_coin_q, change_coin_d;
  logic                  busy_q, busy_d;
  logic                  coin_reject_q, coin_reject_d;
  logic [1:0]            sel_err_q, sel_err_d;

  logic [1:0]            pick_coin;
  logic [CREDIT_W-1:0]   pick_value;
  logic [CREDIT_W-1:0]   coin_value;
  logic [CREDIT_W:0]     coin_sum;
  logic [CREDIT_W-1:0]   price_sel;
  logic                  sel_in_range;
  logic [STOCK_W:0]      refill_sum;

  change_dispenser #(
    .CREDIT_W (CREDIT_W),
    .COIN1    (COIN1),
    .COIN2    (COIN2),
    .COIN3    (COIN3)
  ) u_change_dispenser (
    .remain_i (credit_q),
    .coin_o   (pick_coin),
    .value_o  (pick_value)
  );

  always_comb begin
    case (coin)
      COIN_C1: coin_value = CREDIT_W'(COIN1);
      COIN_C2: coin_value = CREDIT_W'(COIN2);
      COIN_C3: coin_value = CREDIT_W'(COIN3);
      default: coin_value = '0;
    endcase
  end

  assign coin_sum     = {1'b0, credit_q} + {1'b0, coin_value};
  assign price_sel    = PRICES[int'(select_id)*CREDIT_W +: CREDIT_W];
  assign sel_in_range = int'(select_id) < NUM_ITEMS;
  assign refill_sum   = {1'b0, stock_q[refill_id]} + {1'b0, refill_cnt};

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    stock_d       = stock_q;
    item_valid_d  = 1'b0;
    item_id_d     = '0;
    change_coin_d = COIN_NONE;
    busy_d        = 1'b0;
    coin_reject_d = 1'b0;
    sel_err_d     = SEL_OK;

    if (refill_valid && int'(refill_id) < NUM_ITEMS) begin
      stock_d[refill_id] = refill_sum[STOCK_W] ? '1 : refill_sum[STOCK_W-1:0];
    end

    case (state_q)
      IDLE: begin
        if (cancel && credit_q != '0) begin
          state_d       = PAYOUT;
          coin_reject_d = (coin != COIN_NONE);
        end else if (select_valid) begin
          coin_reject_d = (coin != COIN_NONE);
          if (!sel_in_range || stock_q[select_id] == '0) begin
            sel_err_d = SEL_SOLD_OUT;
          end else if (credit_q < price_sel) begin
            sel_err_d = SEL_NO_CREDIT;
          end else begin
            item_valid_d       = 1'b1;
            item_id_d          = select_id;
            // Builds on any same-cycle refill so the decrement follows the saturation.
            stock_d[select_id] = stock_d[select_id] - 1'b1;
            credit_d           = credit_q - price_sel;
            if (credit_q != price_sel) state_d = PAYOUT;
          end
        end else if (coin != COIN_NONE) begin
          if (coin_sum[CREDIT_W]) coin_reject_d = 1'b1;
          else                    credit_d      = coin_sum[CREDIT_W-1:0];
        end
      end
      PAYOUT: begin
        coin_reject_d = (coin != COIN_NONE);
        if (select_valid) sel_err_d = SEL_BUSY;
        change_coin_d = pick_coin;
        // A remainder below the smallest coin cannot be paid; drop it rather than stall.
        credit_d      = (pick_value == '0) ? '0 : credit_q - pick_value;
        if (credit_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == PAYOUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      credit_q      <= '0;
      item_valid_q  <= 1'b0;
      item_id_q     <= '0;
      change_coin_q <= COIN_NONE;
      busy_q        <= 1'b0;
      coin_reject_q <= 1'b0;
      sel_err_q     <= SEL_OK;
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= STOCK_W'(INIT_STOCK);
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      item_valid_q  <= item_valid_d;
      item_id_q     <= item_id_d;
      change_coin_q <= change_coin_d;
      busy_q        <= busy_d;
      coin_reject_q <= coin_reject_d;
      sel_err_q     <= sel_err_d;
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= stock_d[i];
    end
  end

  assign item_valid  = item_valid_q;
  assign item_id     = item_id_q;
  assign change_coin = change_coin_q;
  assign busy        = busy_q;
  assign credit      = credit_q;
  assign coin_reject = coin_reject_q;
  assign sel_err     = sel_err_q;

endmodule
